alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Initiator side of the ALU interface and the control core of the CPU.
- Fetches fixed-width instructions from a read-only instruction memory and decodes opcode and operand fields.
- Reads operands from an internal register file, drives the ALU for one enable cycle, writes the ALU result back and advances the PC.
- Stops when the ALU reports finish; the ALU itself stays a separate responder instance.

Parameters:
DATA_WIDTH, 8, register/ALU data width (package constant, overridable)
BUS_WIDTH, 4, register address width; NREGS = 2**BUS_WIDTH; must be <= DATA_WIDTH
OPCODE_WIDTH, 6, ALU opcode width
PC_WIDTH, 8, instruction address width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, synchronous, active-low
start  in  1  begin/restart execution at PC 0
imem_addr  out  PC_WIDTH  instruction address
imem_rdata  in  INSTR_WIDTH  instruction; valid one cycle after imem_addr; INSTR_WIDTH = OPCODE_WIDTH+3*BUS_WIDTH; layout {opcode, dst, a1, a2}, MSB first
alu_en  out  1  ALU result-capture enable
alu_value1, alu_value2  out  DATA_WIDTH  register operands rf[a1], rf[a2]
alu_addr1, alu_addr2  out  BUS_WIDTH  raw a1/a2 fields; ALU uses them as immediates when opcode bit0/bit1 is set
alu_opcode  out  OPCODE_WIDTH  latched opcode
alu_result  in  DATA_WIDTH  ALU registered result
alu_calc_done, alu_err, alu_finish  in  1  ALU status
busy  out  1  executing (not IDLE/HALT)
halted  out  1  sticky: finish seen
fault  out  1  sticky: alu_err seen
pc  out  PC_WIDTH  current PC
dbg_addr  in  BUS_WIDTH  register debug read address
dbg_data  out  DATA_WIDTH  rf[dbg_addr], combinational

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE; pc=0; all rf=0; IR=0; alu_en=0; busy=0; halted=0; fault=0; alu_* operand outputs 0. Reset mid-instruction aborts it with no writeback.
- FSM: IDLE -> FETCH on start. FETCH: imem_addr=pc -> READ. READ: latch imem_rdata into IR, latch rf[a1]/rf[a2] into operand registers; opcode all-ones -> HALT (halted=1, no alu_en), else -> CALC. CALC: alu_en=1 for exactly one cycle with operands stable -> WRITE. WRITE: if alu_err, fault=1 -> HALT with no writeback. Elif alu_calc_done, rf[dst]<=alu_result, pc<=pc+1 -> FETCH. Else stay in WRITE (alu_en stays 0).
- Latency: 4 cycles per instruction (FETCH, READ, CALC, WRITE). First fetch address appears the cycle after start.
- alu_* outputs come from registers; they change only on the READ->CALC edge.
- PC wraps from 2**PC_WIDTH-1 to 0; no flag.
- start is ignored while busy. In HALT, start clears halted and fault, sets pc=0, goes to FETCH; rf contents are retained.
- Read-after-write: a WRITE completes before the next READ, so there are no hazards and no forwarding.
- Writes to any register (including r0) are permitted.
- dbg_data during a WRITE cycle shows the old value; the new value is visible the next cycle.

Optional Feature:
SEQ_RETIRE_CNT_EN
- Defined: adds output retired_cnt [15:0]. Reset 0; +1 per successful writeback; saturates at 16'hFFFF; cleared on restart from HALT.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared params package holds DATA_WIDTH, BUS_WIDTH, OPCODE_WIDTH, PC_WIDTH, INSTR_WIDTH, HALT_OP (all ones), and a seq_state_t enum {IDLE, FETCH, READ, CALC, WRITE, HALT}.
- One sub-module: seq_regfile, holding NREGS x DATA_WIDTH with 2 sync-latched read ports, 1 debug combinational read port, 1 write port, and synchronous active-low clear.

Test Plan:
1. Reset, start, mem[0]={6'b000011,dst1,a1=5,a2=3}, mem[1]=HALT -> alu_en one pulse at cycle 3 after start; r1=8; halted=1; pc=1.
2. Register ops: r1=8 then mem[1]={6'b001000,2,1,1} -> r2=0; mem[2]={6'b011100,3,1,1} -> r3=8 (AND).
3. Stubbed ALU forces alu_err in WRITE -> fault=1, HALT, dst register unchanged, pc not incremented.
4. Stubbed ALU holds alu_calc_done=0 for 3 cycles -> sequencer stays in WRITE, alu_en=0, then writes back; total 7 cycles for that instruction.
5. Drop rstn in CALC -> next cycle state IDLE, all rf=0, no writeback; start pulse during busy has no effect; restart from HALT resumes at pc=0 with rf retained.
6. PC_WIDTH=2 with no HALT in mem -> pc wraps 3->0; with SEQ_RETIRE_CNT_EN, retired_cnt=5 after 5 writebacks.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared widths, instruction layout and sequencer state encoding for alu_sequencer.
package alu_sequencer_pkg;

    localparam int unsigned DATA_WIDTH   = 8;
    localparam int unsigned BUS_WIDTH    = 4;
    localparam int unsigned OPCODE_WIDTH = 6;
    localparam int unsigned PC_WIDTH     = 8;
    localparam int unsigned INSTR_WIDTH  = OPCODE_WIDTH + 3 * BUS_WIDTH;
    localparam int unsigned NREGS        = 2 ** BUS_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] HALT_OP = '1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StRead,
        StCalc,
        StWrite,
        StHalt
    } seq_state_t;

    // Instruction word, MSB first: {opcode, dst, a1, a2}
    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [BUS_WIDTH-1:0]    dst;
        logic [BUS_WIDTH-1:0]    a1;
        logic [BUS_WIDTH-1:0]    a2;
    } instr_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Sequencer-to-ALU bus; the sequencer is the master, the ALU the responder.
interface alu_sequencer_if;
    import alu_sequencer_pkg::*;

    logic                    alu_en;
    logic [DATA_WIDTH-1:0]   alu_value1;
    logic [DATA_WIDTH-1:0]   alu_value2;
    logic [BUS_WIDTH-1:0]    alu_addr1;
    logic [BUS_WIDTH-1:0]    alu_addr2;
    logic [OPCODE_WIDTH-1:0] alu_opcode;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic                    alu_calc_done;
    logic                    alu_err;
    logic                    alu_finish;

    modport master (
        output alu_en, alu_value1, alu_value2, alu_addr1, alu_addr2, alu_opcode,
        input  alu_result, alu_calc_done, alu_err, alu_finish
    );

    modport slave (
        input  alu_en, alu_value1, alu_value2, alu_addr1, alu_addr2, alu_opcode,
        output alu_result, alu_calc_done, alu_err, alu_finish
    );

endinterface

// File: rtl/alu_sequencer_seq_regfile.sv
// Register file: two registered read ports, one combinational debug port, one write port,
// synchronous active-low clear of every entry.
module seq_regfile
    import alu_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rd_en,
    input  logic [BUS_WIDTH-1:0]  rd_addr1,
    input  logic [BUS_WIDTH-1:0]  rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wr_en,
    input  logic [BUS_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BUS_WIDTH-1:0]  dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    logic [DATA_WIDTH-1:0] rf_q [NREGS];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else begin
            if (wr_en) begin
                rf_q[wr_addr] <= wr_data;
            end
            if (rd_en) begin
                rd_data1 <= rf_q[rd_addr1];
                rd_data2 <= rf_q[rd_addr2];
            end
        end
    end

    assign dbg_data = rf_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// CPU control core: fetch, decode, drive the ALU for one cycle, write back, advance PC.
// Optional SEQ_RETIRE_CNT_EN adds a saturating 16-bit retired-instruction counter port.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    alu_sequencer_if.master        alu,
    output logic                   busy,
    output logic                   halted,
    output logic                   fault,
    output logic [PC_WIDTH-1:0]    pc,
    input  logic [BUS_WIDTH-1:0]   dbg_addr,
    output logic [DATA_WIDTH-1:0]  dbg_data
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]            retired_cnt
`endif
);

    seq_state_t           state_q, state_d;
    instr_t               ir_q, fetched;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic                 halted_q, halted_d;
    logic                 fault_q, fault_d;
    logic                 alu_en_q;
    logic                 ld_op, wb_en, restart;

    assign fetched = imem_rdata;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        ld_op    = 1'b0;
        wb_en    = 1'b0;
        restart  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: state_d = StRead;
            StRead: begin
                if (fetched.opcode == HALT_OP) begin
                    halted_d = 1'b1;
                    state_d  = StHalt;
                end else begin
                    ld_op   = 1'b1;
                    state_d = StCalc;
                end
            end
            StCalc: state_d = StWrite;
            StWrite: begin
                if (alu.alu_err) begin
                    fault_d = 1'b1;
                    state_d = StHalt;
                end else if (alu.alu_calc_done) begin
                    wb_en = 1'b1;
                    pc_d  = pc_q + PC_WIDTH'(1);
                    // A finishing ALU still retires its result, then the core stops
                    if (alu.alu_finish) begin
                        halted_d = 1'b1;
                        state_d  = StHalt;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StHalt: begin
                if (start) begin
                    restart  = 1'b1;
                    halted_d = 1'b0;
                    fault_d  = 1'b0;
                    pc_d     = '0;
                    state_d  = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            ir_q     <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            alu_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            alu_en_q <= ld_op;
            if (ld_op) ir_q <= fetched;
        end
    end

    seq_regfile u_regfile (
        .clk      (clk),
        .rstn     (rstn),
        .rd_en    (ld_op),
        .rd_addr1 (fetched.a1),
        .rd_addr2 (fetched.a2),
        .rd_data1 (alu.alu_value1),
        .rd_data2 (alu.alu_value2),
        .wr_en    (wb_en),
        .wr_addr  (ir_q.dst),
        .wr_data  (alu.alu_result),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] retired_q;

    always_ff @(posedge clk) begin
        if (!rstn || restart) begin
            retired_q <= '0;
        end else if (wb_en && (retired_q != 16'hFFFF)) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign retired_cnt = retired_q;
`endif

    assign alu.alu_en     = alu_en_q;
    assign alu.alu_opcode = ir_q.opcode;
    assign alu.alu_addr1  = ir_q.a1;
    assign alu.alu_addr2  = ir_q.a2;
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign halted         = halted_q;
    assign fault          = fault_q;
    assign busy           = !(state_q inside {StIdle, StHalt});

endmodule
